// File: rtl/pic_rw_ctrl.sv
// CPU read/write strobe decode and ICW1..ICW4 / OCW1..OCW3 register sequencer for an 8259-style PIC.
// Strobe-to-buf_en latency 3 clk edges; write commit lands 4 edges after wr_n rises; no backpressure.
module pic_rw_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    output logic [7:0] dout,
    output logic       buf_en,
    output logic       buf_ino,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vec_base,
    output logic [7:0] icw3,
    output logic       upm,
    output logic       aeoi,
    output logic [7:0] imr,
    output logic       ocw2_stb,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_lvl,
    output logic       ris,
    output logic       smm
);
    typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

    localparam logic [10:0] SYNC_IDLE = {3'b111, 1'b0, 8'h00};

    logic [10:0] sync1_q, sync2_q;
    logic        cs_s, rd_s, wr_s, a0_s;
    logic [7:0]  din_s;
    logic        rd_act, wr_act;

    logic        wr_seen_q, bad_q, commit_q;
    logic        hold_a0_q;
    logic [7:0]  hold_b_q;
    logic [7:0]  dout_q;
    logic        buf_en_q, buf_ino_q;

    state_t      state_q, state_d;
    logic        ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
    logic [4:0]  vec_q, vec_d;
    logic [7:0]  icw3_q, icw3_d, imr_q, imr_d;
    logic        upm_q, upm_d, aeoi_q, aeoi_d;
    logic        ris_q, ris_d, smm_q, smm_d;
    logic        stb_q, stb_d;
    logic [2:0]  cmd_q, cmd_d, lvl_q, lvl_d;

    assign {cs_s, rd_s, wr_s, a0_s, din_s} = sync2_q;
    assign rd_act = ~cs_s & ~rd_s;
    assign wr_act = ~cs_s & ~wr_s;

    // Strobes reset to their inactive (high) level so release never fakes an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= SYNC_IDLE;
            sync2_q   <= SYNC_IDLE;
            wr_seen_q <= 1'b0;
            bad_q     <= 1'b0;
            commit_q  <= 1'b0;
            hold_a0_q <= 1'b0;
            hold_b_q  <= 8'h00;
            dout_q    <= 8'h00;
            buf_en_q  <= 1'b0;
            buf_ino_q <= 1'b0;
        end else begin
            sync1_q   <= {cs_n, rd_n, wr_n, a0, din};
            sync2_q   <= sync1_q;
            wr_seen_q <= wr_act;
            bad_q     <= wr_act ? (bad_q | rd_act) : 1'b0;
            commit_q  <= wr_seen_q & ~wr_act & ~bad_q;
            if (wr_act) begin
                hold_a0_q <= a0_s;
                hold_b_q  <= din_s;
            end
            if (rd_act)
                dout_q <= a0_s ? imr_q : (ris_q ? isr : irr);
            buf_en_q  <= rd_act | wr_act;
            buf_ino_q <= rd_act;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNINIT;
            ltim_q  <= 1'b0;
            sngl_q  <= 1'b0;
            ic4_q   <= 1'b0;
            vec_q   <= 5'd0;
            icw3_q  <= 8'h00;
            upm_q   <= 1'b0;
            aeoi_q  <= 1'b0;
            imr_q   <= 8'h00;
            ris_q   <= 1'b0;
            smm_q   <= 1'b0;
            stb_q   <= 1'b0;
            cmd_q   <= 3'd0;
            lvl_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ltim_q  <= ltim_d;
            sngl_q  <= sngl_d;
            ic4_q   <= ic4_d;
            vec_q   <= vec_d;
            icw3_q  <= icw3_d;
            upm_q   <= upm_d;
            aeoi_q  <= aeoi_d;
            imr_q   <= imr_d;
            ris_q   <= ris_d;
            smm_q   <= smm_d;
            stb_q   <= stb_d;
            cmd_q   <= cmd_d;
            lvl_q   <= lvl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ltim_d  = ltim_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        vec_d   = vec_q;
        icw3_d  = icw3_q;
        upm_d   = upm_q;
        aeoi_d  = aeoi_q;
        imr_d   = imr_q;
        ris_d   = ris_q;
        smm_d   = smm_q;
        stb_d   = 1'b0;
        cmd_d   = cmd_q;
        lvl_d   = lvl_q;
        if (commit_q) begin
            if (!hold_a0_q && hold_b_q[4]) begin
                ltim_d  = hold_b_q[3];
                sngl_d  = hold_b_q[1];
                ic4_d   = hold_b_q[0];
                imr_d   = 8'h00;
                ris_d   = 1'b0;
                smm_d   = 1'b0;
                upm_d   = 1'b0;
                aeoi_d  = 1'b0;
                state_d = W_ICW2;
            end else if (hold_a0_q) begin
                case (state_q)
                    W_ICW2: begin
                        vec_d   = hold_b_q[7:3];
                        state_d = !sngl_q ? W_ICW3 : (ic4_q ? W_ICW4 : READY);
                    end
                    W_ICW3: begin
                        icw3_d  = hold_b_q;
                        state_d = ic4_q ? W_ICW4 : READY;
                    end
                    W_ICW4: begin
                        upm_d   = hold_b_q[0];
                        aeoi_d  = hold_b_q[1];
                        state_d = READY;
                    end
                    READY:   imr_d = hold_b_q;
                    default: ;
                endcase
            end else if (state_q == READY) begin
                if (hold_b_q[4:3] == 2'b00) begin
                    cmd_d = hold_b_q[7:5];
                    lvl_d = hold_b_q[2:0];
                    stb_d = 1'b1;
                end else if (hold_b_q[4:3] == 2'b01) begin
                    if (hold_b_q[1]) ris_d = hold_b_q[0];
                    if (hold_b_q[6]) smm_d = hold_b_q[5];
                end
            end
        end
    end

    assign dout      = dout_q;
    assign buf_en    = buf_en_q;
    assign buf_ino   = buf_ino_q;
    assign init_done = (state_q == READY);
    assign ltim      = ltim_q;
    assign sngl      = sngl_q;
    assign ic4       = ic4_q;
    assign vec_base  = vec_q;
    assign icw3      = icw3_q;
    assign upm       = upm_q;
    assign aeoi      = aeoi_q;
    assign imr       = imr_q;
    assign ocw2_stb  = stb_q;
    assign ocw2_cmd  = cmd_q;
    assign ocw2_lvl  = lvl_q;
    assign ris       = ris_q;
    assign smm       = smm_q;
endmodule

// File: tb/tb_pic_rw_ctrl.sv
// Scoreboard bench for pic_rw_ctrl: CPU bus cycles push expected state, checks pop it at the DUT's output time.
module tb_pic_rw_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0] din = 8'h00, irr = 8'h00, isr = 8'h00;
    logic [7:0] dout, icw3, imr;
    logic       buf_en, buf_ino, init_done, ltim, sngl, ic4, upm, aeoi, ocw2_stb, ris, smm;
    logic [4:0] vec_base;
    logic [2:0] ocw2_cmd, ocw2_lvl;

    pic_rw_ctrl dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .din(din), .irr(irr), .isr(isr), .dout(dout), .buf_en(buf_en), .buf_ino(buf_ino),
        .init_done(init_done), .ltim(ltim), .sngl(sngl), .ic4(ic4), .vec_base(vec_base),
        .icw3(icw3), .upm(upm), .aeoi(aeoi), .imr(imr), .ocw2_stb(ocw2_stb),
        .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl), .ris(ris), .smm(smm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] regs;
        logic        stb;
        logic [5:0]  ocw;
    } exp_t;

    exp_t       wr_sb[$];
    logic [7:0] rd_sb[$];
    int         n_chk = 0;
    int         n_err = 0;

    // Reference model state: 0 uninit, 1 wait ICW2, 2 wait ICW3, 3 wait ICW4, 4 ready.
    int         m_st = 0;
    logic       m_ltim = 0, m_sngl = 0, m_ic4 = 0, m_upm = 0, m_aeoi = 0, m_ris = 0, m_smm = 0, m_stb = 0;
    logic [4:0] m_vec = 0;
    logic [7:0] m_icw3 = 0, m_imr = 0;
    logic [2:0] m_cmd = 0, m_lvl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [28:0] dut_regs();
        return {init_done, ltim, sngl, ic4, vec_base, icw3, upm, aeoi, imr, ris, smm};
    endfunction

    function automatic logic [28:0] mdl_regs();
        return {(m_st == 4), m_ltim, m_sngl, m_ic4, m_vec, m_icw3, m_upm, m_aeoi, m_imr, m_ris, m_smm};
    endfunction

    function automatic logic [7:0] mdl_sel(input logic a);
        return a ? m_imr : (m_ris ? isr : irr);
    endfunction

    task automatic mdl_reset();
        m_st = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_upm = 0; m_aeoi = 0;
        m_ris = 0; m_smm = 0; m_vec = 0; m_icw3 = 0; m_imr = 0; m_cmd = 0; m_lvl = 0;
    endtask

    task automatic mdl_wr(input logic a, input logic [7:0] b);
        m_stb = 0;
        if (a == 0 && b[4]) begin
            m_ltim = b[3]; m_sngl = b[1]; m_ic4 = b[0];
            m_imr = 0; m_ris = 0; m_smm = 0; m_upm = 0; m_aeoi = 0;
            m_st = 1;
        end else if (m_st == 1 && a) begin
            m_vec = b[7:3];
            if (!m_sngl) m_st = 2;
            else if (m_ic4) m_st = 3;
            else m_st = 4;
        end else if (m_st == 2 && a) begin
            m_icw3 = b;
            m_st = m_ic4 ? 3 : 4;
        end else if (m_st == 3 && a) begin
            m_upm = b[0]; m_aeoi = b[1]; m_st = 4;
        end else if (m_st == 4 && a) begin
            m_imr = b;
        end else if (m_st == 4 && b[4:3] == 2'b00) begin
            m_cmd = b[7:5]; m_lvl = b[2:0]; m_stb = 1;
        end else if (m_st == 4 && b[4:3] == 2'b01) begin
            if (b[1]) m_ris = b[0];
            if (b[6]) m_smm = b[5];
        end
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = a; din = b;
        mdl_wr(a, b);
        e.regs = mdl_regs(); e.stb = m_stb; e.ocw = {m_cmd, m_lvl};
        wr_sb.push_back(e);
        repeat (3) @(posedge clk);
        #1 chk("wr_buf", {30'd0, buf_en, buf_ino}, 32'd2);
        @(negedge clk);
        wr_n = 1; cs_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("wr_buf_off", {31'd0, buf_en}, 32'd0);
        chk("stb_early", {31'd0, ocw2_stb}, 32'd0);
        @(posedge clk);
        #1 e = wr_sb.pop_front();
        chk("regs", {3'd0, dut_regs()}, {3'd0, e.regs});
        chk("stb", {31'd0, ocw2_stb}, {31'd0, e.stb});
        chk("ocw2", {26'd0, ocw2_cmd, ocw2_lvl}, {26'd0, e.ocw});
        @(posedge clk);
        #1 chk("stb_clr", {31'd0, ocw2_stb}, 32'd0);
    endtask

    task automatic cpu_rd(input logic a, input logic [7:0] nirr, input logic [7:0] nisr);
        @(negedge clk);
        cs_n = 0; rd_n = 0; a0 = a;
        rd_sb.push_back(mdl_sel(a));
        repeat (3) @(posedge clk);
        #1 chk("rd_buf", {30'd0, buf_en, buf_ino}, 32'd3);
        @(posedge clk);
        #1 chk("rd_dout", {24'd0, dout}, {24'd0, rd_sb.pop_front()});
        irr = nirr; isr = nisr;
        rd_sb.push_back(mdl_sel(a));
        @(posedge clk);
        #1 chk("rd_track", {24'd0, dout}, {24'd0, rd_sb.pop_front()});
        @(negedge clk);
        rd_n = 1; cs_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("rd_buf_off", {30'd0, buf_en, buf_ino}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_regs", {3'd0, dut_regs()}, 32'd0);
        chk("rst_bus", {21'd0, dout, buf_en, buf_ino, ocw2_stb}, 32'd0);
        @(negedge clk); rst = 0;
        repeat (2) @(posedge clk);

        // Single mode, no ICW4.
        cpu_wr(0, 8'h12);
        cpu_wr(1, 8'h40);
        chk("single", {13'd0, sngl, ic4, vec_base, init_done, icw3, upm, aeoi},
            {13'd0, 1'b1, 1'b0, 5'b01000, 1'b1, 8'h00, 2'b00});

        // Cascade with ICW4.
        cpu_wr(0, 8'h11);
        chk("icw1_clr_init", {31'd0, init_done}, 32'd0);
        cpu_wr(1, 8'h48);
        cpu_wr(1, 8'h04);
        cpu_wr(1, 8'h03);
        chk("cascade", {21'd0, init_done, icw3, upm, aeoi}, {21'd0, 1'b1, 8'h04, 2'b11});

        // Operational commands.
        cpu_wr(1, 8'hA5);
        chk("ocw1", {24'd0, imr}, 32'h0000_00A5);
        cpu_wr(0, 8'h62);
        chk("ocw2_fields", {26'd0, ocw2_cmd, ocw2_lvl}, {26'd0, 3'b011, 3'b010});

        // Read-back: IRR, then ISR after OCW3, then IMR.
        irr = 8'h81; isr = 8'h10;
        cpu_rd(0, 8'h83, 8'h10);
        irr = 8'h81;
        cpu_wr(0, 8'h0B);
        chk("ocw3_ris", {31'd0, ris}, 32'd1);
        cpu_rd(0, 8'h81, 8'h30);
        cpu_rd(1, 8'h81, 8'h10);

        // Simultaneous rd/wr: read wins, write must not commit.
        @(negedge clk);
        cs_n = 0; rd_n = 0; wr_n = 0; a0 = 1; din = 8'h3C;
        repeat (4) @(posedge clk);
        #1 chk("both_buf", {30'd0, buf_en, buf_ino}, 32'd3);
        @(negedge clk);
        cs_n = 1; rd_n = 1; wr_n = 1;
        repeat (6) @(posedge clk);
        #1 chk("both_no_commit", {3'd0, dut_regs()}, {3'd0, mdl_regs()});

        // Re-init from READY; a0=0 non-ICW1 write in W_ICW2 is dropped.
        cpu_wr(1, 8'hFF);
        cpu_wr(0, 8'h13);
        chk("reinit", {23'd0, init_done, imr}, 32'd0);
        cpu_wr(0, 8'h20);
        cpu_wr(1, 8'h50);
        cpu_wr(1, 8'h00);

        // Async reset in the middle of a W_ICW3 write strobe.
        cpu_wr(0, 8'h11);
        cpu_wr(1, 8'h48);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = 1; din = 8'h04;
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_buf", {31'd0, buf_en}, 32'd1);
        #2 rst = 1;
        mdl_reset();
        #1 chk("arst_regs", {3'd0, dut_regs()}, 32'd0);
        chk("arst_bus", {21'd0, dout, buf_en, buf_ino, ocw2_stb}, 32'd0);
        @(negedge clk);
        wr_n = 1; cs_n = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (6) @(posedge clk);
        #1 chk("post_rst", {3'd0, dut_regs()}, {3'd0, mdl_regs()});
        cpu_wr(1, 8'h55);

        chk("sb_empty", wr_sb.size() + rd_sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
